// File: rtl/jam_param_engine.sv
// Exhaustive job-assignment search over all N! permutations; reports the optimum total cost and its match count.
// Each permutation takes N+5 cycles. There is no backpressure: Start is taken only in IDLE and Valid pulses for one cycle.
module jam_param_engine #(
  parameter int N    = 8,
  parameter int IDXW = 3,
  parameter int CW   = 7,
  parameter int SUMW = 10,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Mode,
  output logic [IDXW-1:0] W,
  output logic [IDXW-1:0] J,
  input  logic [CW-1:0]   Cost,
  output logic            Busy,
  output logic            Valid,
  output logic [SUMW-1:0] OptCost,
  output logic [CNTW-1:0] MatchCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CMP, S_PIVOT, S_SWAP, S_REV, S_DONE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] perm [N];
  logic [IDXW-1:0] p_idx;
  logic [IDXW:0]   idx;
  logic            mode_q;
  logic            first;
  logic [SUMW-1:0] sum;
  logic [SUMW-1:0] best;
  logic [CNTW-1:0] cnt;

  logic            piv_found;
  logic [IDXW-1:0] piv_pos;
  logic [IDXW-1:0] swp_pos;
  logic [IDXW-1:0] rev_perm [N];
  logic            better;

  always_comb begin
    piv_found = 1'b0;
    piv_pos   = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        piv_found = 1'b1;
        piv_pos   = IDXW'(i);
      end
    end
    swp_pos = p_idx;
    for (int s = 0; s < N; s++) begin
      if (s > int'(p_idx) && perm[s] > perm[p_idx]) swp_pos = IDXW'(s);
    end
    // Tail after the pivot is strictly decreasing; mirroring it gives the next lexicographic order.
    for (int i = 0; i < N; i++) begin
      rev_perm[i] = perm[i];
      if (i > int'(p_idx)) rev_perm[i] = perm[IDXW'(int'(p_idx) + N - i)];
    end
    better = mode_q ? (sum > best) : (sum < best);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      W          <= '0;
      J          <= '0;
      Busy       <= 1'b0;
      Valid      <= 1'b0;
      OptCost    <= '0;
      MatchCount <= '0;
      for (int i = 0; i < N; i++) perm[i] <= IDXW'(i);
      p_idx      <= '0;
      idx        <= '0;
      mode_q     <= 1'b0;
      first      <= 1'b0;
      sum        <= '0;
      best       <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            mode_q <= Mode;
            for (int i = 0; i < N; i++) perm[i] <= IDXW'(i);
            first  <= 1'b1;
            idx    <= '0;
            W      <= '0;
            J      <= '0;
            Busy   <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Address idx is already on W/J; issue idx+1 and absorb the cost for idx-1.
          if (idx != '0) sum <= (idx == 1) ? SUMW'(Cost) : sum + SUMW'(Cost);
          if (int'(idx) < N - 1) begin
            W <= IDXW'(idx + 1'b1);
            J <= perm[IDXW'(idx + 1'b1)];
          end
          if (int'(idx) == N) begin
            idx   <= '0;
            state <= S_CMP;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_CMP: begin
          if (first || better) begin
            best  <= sum;
            cnt   <= CNTW'(1);
            first <= 1'b0;
          end else if (sum == best && cnt != '1) begin
            cnt <= cnt + CNTW'(1);
          end
          state <= S_PIVOT;
        end
        S_PIVOT: begin
          if (piv_found) begin
            p_idx <= piv_pos;
            state <= S_SWAP;
          end else begin
            OptCost    <= best;
            MatchCount <= cnt;
            Valid      <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_SWAP: begin
          perm[p_idx]   <= perm[swp_pos];
          perm[swp_pos] <= perm[p_idx];
          state         <= S_REV;
        end
        S_REV: begin
          // perm[0] is never inside the reversed tail, so it is safe to prefetch here.
          for (int i = 0; i < N; i++) perm[i] <= rev_perm[i];
          W     <= '0;
          J     <= rev_perm[0];
          idx   <= '0;
          state <= S_FETCH;
        end
        S_DONE: begin
          Valid <= 1'b0;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_param_engine.sv
// Bench for jam_param_engine using one N=3 instance and one N=6, CNTW=8 instance.
// A Valid-driven monitor checks each result against a queue of expected results.
module tb_jam_param_engine;

  typedef struct {
    int opt;
    int cnt;
  } exp_t;

  logic clk;
  logic rst3, start3, mode3, busy3, valid3;
  logic [1:0]  w3, j3;
  logic [6:0]  cost3;
  logic [8:0]  opt3;
  logic [15:0] cnt3;

  logic rst6, start6, mode6, busy6, valid6;
  logic [2:0] w6, j6;
  logic [6:0] cost6;
  logic [9:0] opt6;
  logic [7:0] cnt6;

  int tab3 [3][3];
  int tab6 [6][6];
  exp_t q3[$];
  exp_t q6[$];
  int checks = 0;
  int errors = 0;

  jam_param_engine #(.N(3), .IDXW(2), .CW(7), .SUMW(9), .CNTW(16)) u3 (
    .CLK(clk), .RST(rst3), .Start(start3), .Mode(mode3), .W(w3), .J(j3), .Cost(cost3),
    .Busy(busy3), .Valid(valid3), .OptCost(opt3), .MatchCount(cnt3));

  jam_param_engine #(.N(6), .IDXW(3), .CW(7), .SUMW(10), .CNTW(8)) u6 (
    .CLK(clk), .RST(rst6), .Start(start6), .Mode(mode6), .W(w6), .J(j6), .Cost(cost6),
    .Busy(busy6), .Valid(valid6), .OptCost(opt6), .MatchCount(cnt6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cost3 <= 7'(tab3[w3][j3]);
    cost6 <= 7'(tab6[w6][j6]);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL u3_unexpected_valid got opt=%0d cnt=%0d expected no Valid", opt3, cnt3);
      end else begin
        e = q3.pop_front();
        if (opt3 !== 9'(e.opt) || cnt3 !== 16'(e.cnt)) begin
          errors++;
          $display("FAIL u3_result got opt=%0d cnt=%0d expected opt=%0d cnt=%0d", opt3, cnt3, e.opt, e.cnt);
        end
      end
    end
    if (valid6) begin
      checks++;
      if (q6.size() == 0) begin
        errors++;
        $display("FAIL u6_unexpected_valid got opt=%0d cnt=%0d expected no Valid", opt6, cnt6);
      end else begin
        e = q6.pop_front();
        if (opt6 !== 10'(e.opt) || cnt6 !== 8'(e.cnt)) begin
          errors++;
          $display("FAIL u6_result got opt=%0d cnt=%0d expected opt=%0d cnt=%0d", opt6, cnt6, e.opt, e.cnt);
        end
      end
    end
  end

  // Brute force over all 6^6 index tuples, keeping only those that are permutations.
  task automatic model6(input int mode, output int opt, output int cnt);
    bit seeded = 0;
    opt = 0;
    cnt = 0;
    for (int c = 0; c < 46656; c++) begin
      int x = c;
      int s = 0;
      bit ok = 1;
      bit [5:0] used = '0;
      for (int i = 0; i < 6; i++) begin
        int d = x % 6;
        x = x / 6;
        if (used[d]) ok = 0;
        used[d] = 1'b1;
        s += tab6[i][d];
      end
      if (ok) begin
        if (!seeded || (mode == 0 && s < opt) || (mode == 1 && s > opt)) begin
          opt = s; cnt = 1; seeded = 1;
        end else if (s == opt) begin
          cnt++;
        end
      end
    end
    if (cnt > 255) cnt = 255;
  endtask

  task automatic run3(input logic m, input int eo, input int ec, input string nm);
    exp_t e;
    bit seen = 0;
    e.opt = eo; e.cnt = ec;
    q3.push_back(e);
    @(negedge clk); start3 = 1'b1; mode3 = m;
    @(negedge clk); start3 = 1'b0;
    chk({nm, "_busy_after_start"}, busy3, 1);
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (valid3) seen = 1;
    end
    chk({nm, "_valid_seen"}, seen, 1);
    if (!seen) q3.delete();
  endtask

  task automatic run6(input logic m, input int eo, input int ec, input string nm);
    exp_t e;
    bit seen = 0;
    int drops = 0;
    e.opt = eo; e.cnt = ec;
    q6.push_back(e);
    @(negedge clk); start6 = 1'b1; mode6 = m;
    @(negedge clk); start6 = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (!busy6) drops++;
      @(negedge clk);
      if (valid6) seen = 1;
    end
    chk({nm, "_valid_seen"}, seen, 1);
    chk({nm, "_busy_drops"}, drops, 0);
    if (!seen) q6.delete();
    @(negedge clk);
    chk({nm, "_busy_after_done"}, busy6, 0);
  endtask

  initial begin
    int eo, ec;
    bit seen;
    rst3 = 1'b1; rst6 = 1'b1;
    start3 = 1'b0; start6 = 1'b0; mode3 = 1'b0; mode6 = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) tab3[i][j] = (i + 1) * (j + 1);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) tab6[i][j] = 1;
    repeat (3) @(negedge clk);
    rst3 = 1'b0; rst6 = 1'b0;

    chk("rst_opt3", opt3, 0);
    chk("rst_cnt3", cnt3, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_valid3", valid3, 0);
    chk("rst_w3", w3, 0);
    chk("rst_j3", j3, 0);
    chk("rst_opt6", opt6, 0);
    chk("rst_busy6", busy6, 0);

    // Products table: the anti-diagonal gives the minimum and the identity the maximum.
    run3(1'b0, 10, 1, "n3_min");
    run3(1'b1, 14, 1, "n3_max");
    repeat (4) @(negedge clk);
    chk("n3_opt_holds", opt3, 14);

    // Start during Busy and on the Valid cycle must both be dropped.
    begin
      exp_t e;
      e.opt = 10; e.cnt = 1;
      q3.push_back(e);
      @(negedge clk); start3 = 1'b1; mode3 = 1'b0;
      @(negedge clk); start3 = 1'b0;
      repeat (3) @(negedge clk);
      start3 = 1'b1; mode3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      seen = 0;
      for (int c = 0; c < 2000 && !seen; c++) begin
        @(negedge clk);
        if (valid3) seen = 1;
      end
      chk("n3_ignore_valid_seen", seen, 1);
      start3 = 1'b1;
      @(negedge clk); start3 = 1'b0;
      repeat (5) @(negedge clk);
      chk("n3_ignore_no_restart", busy3, 0);
    end

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) tab3[i][j] = 1;
    run3(1'b0, 3, 6, "n3_ones");

    run6(1'b0, 6, 255, "n6_ones_sat");
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) tab6[i][j] = 5;
    run6(1'b1, 30, 255, "n6_fives_sat");

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++) tab6[i][j] = int'($urandom_range(127, 0));
    @(negedge clk); start6 = 1'b1; mode6 = 1'b0;
    @(negedge clk); start6 = 1'b0;
    repeat (3000) @(negedge clk);
    rst6 = 1'b1;
    @(negedge clk); rst6 = 1'b0;
    chk("midrst_opt6", opt6, 0);
    chk("midrst_cnt6", cnt6, 0);
    chk("midrst_busy6", busy6, 0);
    chk("midrst_valid6", valid6, 0);
    repeat (50) @(negedge clk);
    chk("midrst_stays_idle", busy6, 0);

    model6(0, eo, ec);
    run6(1'b0, eo, ec, "n6_rand_min");
    model6(1, eo, ec);
    run6(1'b1, eo, ec, "n6_rand_max");

    repeat (5) @(negedge clk);
    chk("q3_drained", q3.size(), 0);
    chk("q6_drained", q6.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
